// File: rtl/dna_loader.sv
// Serial 2-bit nucleotide loader: writes bases into sequence memory, then hands
// the length to the search FSM. Over-length sequences are drained and flagged.
module dna_loader #(
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned AW      = 10
) (
  input  logic          clock,
  input  logic          reset_N,
  input  logic          in_valid,
  input  logic [1:0]    in_base,
  input  logic          in_last,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_wdata,
  output logic [15:0]   dna_length,
  output logic          ready,
  input  logic          done,
  output logic          error
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    HANDOFF = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_armed;
  logic [CW-1:0]   r_count;
  logic            w_xfer;

  // r_armed keeps in_ready low until the first edge after reset release
  assign in_ready = r_armed & (r_state != HANDOFF);
  assign w_xfer   = in_valid & in_ready;

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_state    <= LOAD;
      r_armed    <= 1'b0;
      r_count    <= '0;
      dna_length <= '0;
      ready      <= 1'b0;
      error      <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      r_armed <= 1'b1;
      mem_we  <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= r_count[AW-1:0];
            mem_wdata <= in_base;
            r_count   <= r_count + CW'(1);
            // in_last wins over the length limit: a full-length sequence is legal
            if (in_last) begin
              dna_length <= r_count + CW'(1);
              ready      <= 1'b1;
              r_state    <= HANDOFF;
            end else if (r_count == LAST_IDX) begin
              error   <= 1'b1;
              r_state <= DRAIN;
            end
          end
        end
        HANDOFF: begin
          if (done) begin
            ready   <= 1'b0;
            r_count <= '0;
            r_state <= LOAD;
          end
        end
        DRAIN: begin
          if (w_xfer && in_last) begin
            r_count    <= '0;
            dna_length <= '0;
            r_state    <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_loader.sv
// Directed bench for dna_loader with a reduced memory depth.
module tb_dna_loader;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned AW      = 4;

  logic          clock = 1'b0;
  logic          reset_N;
  logic          in_valid;
  logic [1:0]    in_base;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_wdata;
  logic [15:0]   dna_length;
  logic          ready;
  logic          done;
  logic          error;

  int total = 0;
  int bad   = 0;

  dna_loader #(.MAX_LEN(MAX_LEN), .AW(AW)) dut (
    .clock(clock), .reset_N(reset_N), .in_valid(in_valid), .in_base(in_base),
    .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .dna_length(dna_length), .ready(ready), .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One transfer: drive on negedge, check the registered write just after posedge
  task automatic send(input logic [1:0] b, input logic last, input logic d,
                      input logic exp_we, input int exp_addr);
    @(negedge clock);
    in_valid = 1'b1; in_base = b; in_last = last; done = d;
    check("in_ready_before_xfer", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0; done = 1'b0;
    check("mem_we", 32'(mem_we), 32'(exp_we));
    if (exp_we) begin
      check("mem_addr", 32'(mem_addr), 32'(exp_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(b));
    end
  endtask

  task automatic bubble();
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock); #1;
    check("bubble_no_we", 32'(mem_we), 32'd0);
  endtask

  task automatic pulse_done();
    @(negedge clock); done = 1'b1;
    @(posedge clock); #1; done = 1'b0;
    check("ready_after_done", 32'(ready), 32'd0);
    check("in_ready_after_done", 32'(in_ready), 32'd1);
  endtask

  task automatic check_handoff(input int len, input logic err);
    check("ready", 32'(ready), 32'd1);
    check("dna_length", 32'(dna_length), 32'(len));
    check("in_ready_handoff", 32'(in_ready), 32'd0);
    check("error", 32'(error), 32'(err));
  endtask

  initial begin
    reset_N = 1'b0; in_valid = 1'b0; in_base = 2'b00; in_last = 1'b0; done = 1'b0;
    #12;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_len", 32'(dna_length), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clock); reset_N = 1'b1; #1;
    check("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    check("in_ready_after_edge", 32'(in_ready), 32'd1);

    // A,C,G,T continuous
    send(2'b00, 1'b0, 1'b0, 1'b1, 0);
    send(2'b01, 1'b0, 1'b0, 1'b1, 1);
    send(2'b10, 1'b0, 1'b0, 1'b1, 2);
    send(2'b11, 1'b1, 1'b0, 1'b1, 3);
    check_handoff(4, 1'b0);
    repeat (2) @(posedge clock); #1;
    check("ready_held", 32'(ready), 32'd1);
    pulse_done();

    // Bubbles: valid 1,0,0,1,1
    send(2'b10, 1'b0, 1'b0, 1'b1, 0);
    bubble();
    bubble();
    send(2'b01, 1'b0, 1'b0, 1'b1, 1);
    send(2'b11, 1'b1, 1'b0, 1'b1, 2);
    check_handoff(3, 1'b0);
    pulse_done();

    // Spurious done mid-load is ignored
    send(2'b11, 1'b0, 1'b0, 1'b1, 0);
    send(2'b00, 1'b0, 1'b1, 1'b1, 1);
    check("ready_spurious", 32'(ready), 32'd0);
    send(2'b01, 1'b1, 1'b0, 1'b1, 2);
    check_handoff(3, 1'b0);
    pulse_done();

    // Full-length sequence
    for (int i = 0; i < MAX_LEN; i++)
      send(2'(i % 4), (i == MAX_LEN - 1), 1'b0, 1'b1, i);
    check_handoff(MAX_LEN, 1'b0);
    pulse_done();

    // Overflow: MAX_LEN+3 bases
    for (int i = 0; i < MAX_LEN + 3; i++) begin
      send(2'(3 - (i % 4)), (i == MAX_LEN + 2), 1'b0, (i < MAX_LEN), i);
      check("ovf_no_ready", 32'(ready), 32'd0);
      if (i == MAX_LEN - 1) check("ovf_error_set", 32'(error), 32'd1);
    end
    check("ovf_back_to_load", 32'(in_ready), 32'd1);
    check("ovf_len_cleared", 32'(dna_length), 32'd0);
    send(2'b01, 1'b0, 1'b0, 1'b1, 0);
    send(2'b10, 1'b1, 1'b0, 1'b1, 1);
    check_handoff(2, 1'b1);
    pulse_done();

    // Reset mid-load after 2 of 5 bases
    send(2'b11, 1'b0, 1'b0, 1'b1, 0);
    send(2'b11, 1'b0, 1'b0, 1'b1, 1);
    @(negedge clock); #2; reset_N = 1'b0; #1;
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_len", 32'(dna_length), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clock); reset_N = 1'b1;
    @(posedge clock); #1;
    send(2'b10, 1'b1, 1'b0, 1'b1, 0);
    check_handoff(1, 1'b0);
    pulse_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/dna_loader.md
Name: dna_loader

Overview:
- Upstream feeder for the DNA pattern-search FSM.
- Accepts a serial stream of 2-bit nucleotide codes over a valid/ready handshake and writes each base into the sequence memory at consecutive addresses.
- Counts the bases, then presents dna_length and holds ready to the search stage until that stage reports done.
- Flags over-length and empty sequences as error instead of handing them off.

Parameters:
- MAX_LEN, 1024: memory depth in bases; legal lengths are 1..MAX_LEN.
- AW, 10: memory address width; must satisfy 2**AW >= MAX_LEN.

Ports:
- clock  input  1  system clock, rising edge.
- reset_N  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream base is valid.
- in_base  input  2  nucleotide code: A=00, C=01, G=10, T=11.
- in_last  input  1  qualifies the final base of a sequence; sampled only when in_valid=1.
- in_ready  output  1  loader accepts a base this cycle.
- mem_we  output  1  sequence-memory write strobe.
- mem_addr  output  AW  write address.
- mem_wdata  output  2  write data.
- dna_length  output  16  number of bases loaded; zero-extended.
- ready  output  1  to search FSM: sequence loaded and valid.
- done  input  1  from search FSM: search finished.
- error  output  1  sticky: over-length or empty sequence.

Behaviour:
- Reset (async, reset_N=0): state=LOAD, count=0, dna_length=0, ready=0, error=0, mem_we=0, mem_addr=0, mem_wdata=0. in_ready goes to 1 on the first clock edge after reset_N rises.
- Transfer: occurs on a rising edge with in_valid & in_ready. in_ready is combinational from state only, never from in_valid.
- State LOAD, in_ready=1. On each transfer:
  - Register mem_we=1, mem_addr=count, mem_wdata=in_base. The write is visible one cycle after the transfer.
  - Increment count.
  - If in_last=1: load dna_length=count+1 and go to HANDOFF.
  - If count reaches MAX_LEN without in_last: set error=1 and go to DRAIN. MAX_LEN writes occur; no write at address MAX_LEN.
- A cycle with no transfer leaves mem_we=0 on the next cycle.
- State HANDOFF, in_ready=0, ready=1:
  - ready asserts the cycle after the in_last transfer. By then the final mem write has been performed on that same edge.
  - ready stays high until done=1 is sampled.
  - Then: ready=0, count=0, return to LOAD. in_ready is 1 on the next cycle.
  - done while in LOAD or DRAIN is ignored.
- State DRAIN, in_ready=1:
  - Accept and discard bases (mem_we=0) until a transfer with in_last=1.
  - Then: count=0, dna_length=0, return to LOAD. error stays 1.
- Empty sequence: none is possible, since every in_last accompanies a base. dna_length=0 is never presented with ready=1.
- error clears only on reset.
- Length width: count is 16 bits. MAX_LEN must not exceed 65535.
- Simultaneous in_last and count==MAX_LEN-1: a legal full-length sequence. Go to HANDOFF with dna_length=MAX_LEN, error=0.
- Reset mid-operation: all state clears immediately, including ready. Partial memory contents are not cleared and are don't-care.

Test Plan:
- Load 4 bases A,C,G,T, in_last on the 4th, with in_valid continuous:
  - mem writes addr 0..3 data 00,01,10,11.
  - ready=1 the cycle after the 4th transfer; dna_length=4; in_ready=0.
  - Pulse done → ready=0 next cycle, in_ready=1.
- Bubbles: in_valid toggles 1,0,0,1,1 for a 3-base sequence → exactly 3 writes at addr 0,1,2; no mem_we during bubbles; dna_length=3.
- Full-length: MAX_LEN bases with in_last on the last → dna_length=MAX_LEN, error=0, ready=1.
- Overflow: MAX_LEN+3 bases, in_last on the last → error=1 after the MAX_LEN-th transfer, then:
  - no write beyond addr MAX_LEN-1;
  - ready never asserts;
  - loader returns to LOAD after in_last;
  - a subsequent 2-base sequence loads normally with dna_length=2 and error still 1.
- Reset mid-load: assert reset_N=0 after 2 of 5 bases → ready=0, error=0, dna_length=0 asynchronously. After release, a fresh 1-base sequence gives dna_length=1, written at addr 0.
- Spurious done in LOAD: pulse done mid-load → no effect; count and writes continue uninterrupted.
